// File: rtl/mcp3_arb016.sv
// rtl/mcp3_arb016.sv - 16-way round-robin arbiter with hold-timeout watchdog
module mcp3_arb016 #(
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_req,
    input  logic [15:0] i_req_en,
    input  logic        i_done,
    output logic        o_grant_valid,
    output logic [3:0]  o_grant_id,
    output logic [15:0] o_grant_onehot,
    output logic        o_timeout_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        r_state;
    logic [3:0]        r_rr_ptr;
    logic [3:0]        r_grant_id;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_timeout_err;

    logic [15:0]       w_elig;
    logic              w_found;
    logic [3:0]        w_winner;
    logic              w_timeout;

    assign w_elig = i_req & i_req_en;

    // Search upward from rr_ptr with wrap; the loop runs from the farthest
    // offset down so the nearest eligible requester is written last and wins.
    always_comb begin
        logic [3:0] v_idx;
        w_found  = 1'b0;
        w_winner = 4'd0;
        v_idx    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            v_idx = r_rr_ptr + 4'(i);
            if (w_elig[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // hold_cnt is 0 in the first grant cycle, so MAX_HOLD-1 marks the last allowed cycle.
    always_comb begin
        w_timeout = 1'b0;
        if (MAX_HOLD != 0) begin
            w_timeout = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
        end
    end

    // Arbitration FSM: pick in IDLE, hold in GRANT until done or watchdog expiry.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 4'd0;
            r_grant_id    <= 4'd0;
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_grant_id <= w_winner;
                        r_hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                    if (i_done) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= r_grant_id + 4'd1;
                    end else if (w_timeout) begin
                        r_state       <= S_IDLE;
                        r_rr_ptr      <= r_grant_id + 4'd1;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant_valid  = (r_state == S_GRANT);
    assign o_grant_id     = r_grant_id;
    assign o_grant_onehot = o_grant_valid ? (16'd1 << r_grant_id) : 16'd0;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_mcp3_arb016.sv
// tb/tb_mcp3_arb016.sv - directed self-checking bench for mcp3_arb016
module tb_mcp3_arb016;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] req_en;
    logic        done;
    logic        gv;
    logic [3:0]  gid;
    logic [15:0] goh;
    logic        terr;

    int n_pass  = 0;
    int n_total = 0;

    mcp3_arb016 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req          (req),
        .i_req_en       (req_en),
        .i_done         (done),
        .o_grant_valid  (gv),
        .o_grant_id     (gid),
        .o_grant_onehot (goh),
        .o_timeout_err  (terr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] id);
        chk({tag, "_valid"}, {31'd0, gv}, 32'd1);
        chk({tag, "_id"}, {28'd0, gid}, {28'd0, id});
        chk({tag, "_onehot"}, {16'd0, goh}, 32'd1 << id);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, gv}, 32'd0);
        chk({tag, "_onehot"}, {16'd0, goh}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 16'hFFFF; req_en = 16'hFFFF; done = 1'b0;

        // Reset held two cycles
        tick();
        chk_idle("rst1");
        chk("rst1_id", {28'd0, gid}, 32'd0);
        chk("rst1_terr", {31'd0, terr}, 32'd0);
        tick();
        chk_idle("rst2");
        chk("rst2_id", {28'd0, gid}, 32'd0);
        chk("rst2_terr", {31'd0, terr}, 32'd0);
        rst = 1'b0;
        tick();
        chk_grant("first", 4'd0);
        req = 16'h0000; done = 1'b1;
        tick();
        chk_idle("first_rel");
        done = 1'b0;

        // Single requester 4, done in third grant cycle
        req = 16'h0010;
        tick(); chk_grant("single_n1", 4'd4);
        tick(); chk_grant("single_n2", 4'd4);
        tick(); chk_grant("single_n3", 4'd4);
        done = 1'b1; req = 16'h0000;
        tick();
        chk_idle("single_n4");
        chk("single_n4_id_hold", {28'd0, gid}, 32'd4);
        done = 1'b0;
        // rr_ptr now 5: bits 0 and 5 requested, 5 must win
        req = 16'h0021;
        tick(); chk_grant("after_single", 4'd5);
        done = 1'b1; req = 16'h0000;
        tick(); chk_idle("after_single_rel");
        done = 1'b0;

        // Round-robin between 0 and 15 (rr_ptr=6 so 15 first)
        req = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_grant($sformatf("rr%0d", k), (k % 2 == 0) ? 4'd15 : 4'd0);
            done = 1'b1;
            tick();
            chk_idle($sformatf("rr%0d_rel", k));
            chk("rr_no_terr", {31'd0, terr}, 32'd0);
            done = 1'b0;
        end
        req = 16'h0000;

        // Wrap search: release 14 then rr_ptr=15, 0 must win over 14
        req = 16'h4000;
        tick(); chk_grant("wrap14", 4'd14);
        done = 1'b1; req = 16'h0000;
        tick(); chk_idle("wrap14_rel");
        done = 1'b0;
        req = 16'h4001;
        tick(); chk_grant("wrap0", 4'd0);
        done = 1'b1; req = 16'h0000;
        tick(); done = 1'b0;

        // Masking: requester 1 disabled (rr_ptr=1)
        req = 16'h0006; req_en = 16'hFFFD;
        tick(); chk_grant("mask", 4'd2);
        done = 1'b1; req = 16'h0002;
        tick(); done = 1'b0;
        chk_idle("mask_rel");
        tick(); chk_idle("mask_blk1");
        tick(); chk_idle("mask_blk2");
        req_en = 16'hFFFF;
        tick(); chk_grant("unmask", 4'd1);
        done = 1'b1; req = 16'h0000;
        tick(); done = 1'b0;

        // Timeout: grant 8 (rr_ptr=2), never done
        req = 16'h0100;
        tick(); chk_grant("to_c1", 4'd8);
        req = 16'h0000;
        chk("to_c1_terr", {31'd0, terr}, 32'd0);
        tick(); chk_grant("to_c2", 4'd8);
        tick(); chk_grant("to_c3", 4'd8);
        tick(); chk_grant("to_c4", 4'd8);
        chk("to_c4_terr", {31'd0, terr}, 32'd0);
        tick();
        chk_idle("to_c5");
        chk("to_c5_terr", {31'd0, terr}, 32'd1);
        tick();
        chk("to_c6_terr", {31'd0, terr}, 32'd0);
        // rr_ptr=9: bits 0 and 9, 9 wins; done coincides with the timeout cycle
        req = 16'h0201;
        tick(); chk_grant("tod_c1", 4'd9);
        req = 16'h0000;
        tick(); tick(); tick();
        chk_grant("tod_c4", 4'd9);
        done = 1'b1;
        tick();
        chk_idle("tod_rel");
        chk("tod_rel_terr", {31'd0, terr}, 32'd0);
        done = 1'b0;
        tick();
        chk("tod_after_terr", {31'd0, terr}, 32'd0);

        // Reset mid-grant for id 9 (rr_ptr=10)
        req = 16'h0200;
        tick(); chk_grant("mid_g", 4'd9);
        rst = 1'b1;
        tick();
        chk_idle("mid_rst");
        chk("mid_rst_terr", {31'd0, terr}, 32'd0);
        rst = 1'b0; req = 16'hFFFF;
        tick(); chk_grant("mid_ptr0", 4'd0);
        done = 1'b1;
        tick(); done = 1'b0;

        // Fairness: all eligible, next 16 grants are 1..15 then 0
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("fair%0d", k), {27'd0, gv, gid}, {27'd0, 1'b1, 4'(k + 1)});
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcp3_arb016.md
Name: mcp3_arb016

Overview:
- 16-way round-robin arbiter that shares one resource between 16 requesters.
- Selects a winner, issues it an encoded grant and a one-hot grant (4-to-16 decode of the winner), and holds the grant until the winner signals done.
- A hold-timeout watchdog stops a stuck requester from locking the resource.
- Sits between AFP command engines and a shared engine slot.

Parameters:
- MAX_HOLD, 0, number of cycles a grant may be held without done before forced release; 0 disables the timeout.
- HOLD_W, 8, width of the hold counter; MAX_HOLD must be ≤ 2^HOLD_W−1.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  synchronous, active-high reset.
- req  in  16  level request per requester; bit i = requester i.
- req_en  in  16  per-requester enable; a request counts only when req[i] & req_en[i].
- done  in  1  current grant holder has finished; sampled only while grant_valid=1.
- grant_valid  out  1  a grant is active.
- grant_id  out  4  encoded winner.
- grant_onehot  out  16  one-hot winner: bit grant_id set when grant_valid=1, all zero otherwise.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset: synchronous; all state and outputs update on the rising clock edge.
  - State IDLE, rr_ptr=0, hold_cnt=0.
  - grant_valid=0, grant_id=0, grant_onehot=0, timeout_err=0.
  - Reset asserted mid-grant returns to IDLE with rr_ptr=0 on the next edge; no timeout_err.
- Eligible vector: elig = req & req_en.
- IDLE state:
  - If elig≠0, the winner is the first set bit of elig searching upward from rr_ptr and wrapping 15→0.
  - Next edge: state GRANT, grant_valid=1, grant_id=winner, grant_onehot=decode(winner), hold_cnt=0.
  - Latency: elig nonzero in cycle N gives grant_valid=1 in cycle N+1.
  - If elig=0, stay in IDLE.
- GRANT state:
  - grant_id and grant_onehot are frozen for the whole grant.
  - The grant is independent of req/req_en after it is issued; the holder may drop req.
  - hold_cnt increments each GRANT cycle and saturates at its maximum.
  - If done=1 in a GRANT cycle: next edge state IDLE, grant_valid=0, grant_onehot=0, grant_id holds its last value, rr_ptr=(grant_id+1) mod 16.
  - grant_valid stays high through the done cycle.
  - The release cycle is always followed by at least one IDLE cycle, so grants are never back-to-back.
- Timeout (MAX_HOLD>0):
  - If grant_valid has been high for MAX_HOLD cycles with no done, release on the edge ending the MAX_HOLD-th cycle.
  - Release is identical to a done release: same rr_ptr advance, plus timeout_err=1 for the next cycle only.
- Simultaneous done and timeout in the same cycle: done wins, no timeout_err.
- done in IDLE is ignored.
- rr_ptr update rules:
  - rr_ptr wraps 15→0 via 4-bit arithmetic.
  - rr_ptr changes only on release, never on grant issue.
- Fairness: with all requests continuously eligible, each requester receives exactly one grant per 16 grants.
- req_en change during GRANT has no effect on the current grant; it applies at the next IDLE arbitration.

Test Plan:
- Reset:
  - Stimulus: assert reset for 2 cycles with req=0xFFFF, req_en=0xFFFF.
  - Required: grant_valid=0, grant_onehot=0x0000, grant_id=0, timeout_err=0 during reset.
  - Required: first grant after reset is id 0, onehot 0x0001, one cycle after reset deasserts.
- Single requester:
  - Stimulus: req=0x0010, req_en=0xFFFF in cycle N; done in cycle N+3.
  - Required: grant_valid high cycles N+1..N+3, grant_id=4, onehot=0x0010; grant_valid=0 in N+4.
  - Required: the next arbitration searches upward from rr_ptr=5.
- Round-robin and wrap:
  - Stimulus: req=0x8001 held, done one cycle after each grant.
  - Required: grant sequence 0, 15, 0, 15, … with rr_ptr alternating 1 and 0.
- Wrap search:
  - Stimulus: grant id 14 released (rr_ptr=15), then req=0x4001.
  - Required: grant_id=0.
- Masking:
  - Stimulus: req=0x0006, req_en=0xFFFD.
  - Required: grant_id=2, onehot=0x0004; requester 1 is never granted while masked.
- Timeout with MAX_HOLD=4:
  - Stimulus: grant with no done.
  - Required: grant_valid high exactly 4 cycles; timeout_err=1 in the 5th cycle with grant_valid=0; rr_ptr advances.
  - Stimulus: repeat with done in the 4th cycle.
  - Required: timeout_err stays 0.
- Reset mid-grant:
  - Stimulus: reset during GRANT for id 9.
  - Required: grant_valid=0 next cycle, rr_ptr=0, no timeout_err.
